// File: rtl/tqvp_cattuto_ws2812b_receiver.sv
// WS2812B single-wire receiver: times each high pulse, assembles 24-bit GRB pixels,
// captures the pixel at the CPU-selected index and flags frame end, errors and overruns.
module tqvp_cattuto_ws2812b_receiver #(
    parameter int DIN_BIT    = 1,
    parameter int T_THRESH   = 38,
    parameter int T_HIGH_MAX = 160,
    parameter int T_RESET    = 3200,
    parameter int CNT_W      = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    typedef enum logic [1:0] {S_RESYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] HMAX_M1  = CNT_W'(T_HIGH_MAX - 1);
    localparam logic [CNT_W-1:0] RESET_M1 = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic             din_q;
    logic [CNT_W-1:0] cnt_q;
    logic [22:0]      shift_q;
    logic [4:0]       bit_cnt_q;
    logic [8:0]       idx_q;
    logic [7:0]       index_q, count_q;
    logic [7:0]       g_q, r_q, b_q;
    logic             valid_q, frame_done_q, error_q, overrun_q;

    logic             din, rise, fall, busy;
    logic [CNT_W-1:0] cnt_inc;
    logic [23:0]      shift_d;
    logic             pixel_done, capture, high_err, frame_end;
    logic [3:0]       clr;
    logic             valid_d, frame_done_d, error_d, overrun_d;
    logic             unused_ui;

    assign din       = ui_in[DIN_BIT];
    assign unused_ui = ^ui_in;
    assign rise      = din & ~din_q;
    assign fall      = ~din & din_q;
    assign busy      = (state_q == S_HIGH) || (state_q == S_LOW);
    assign uo_out    = 8'h00;

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign shift_d    = {shift_q, (cnt_q > THRESH)};
    assign pixel_done = (state_q == S_HIGH) && fall && (bit_cnt_q == 5'd23);
    assign capture    = pixel_done && (idx_q == {1'b0, index_q});
    assign high_err   = (state_q == S_HIGH) && !fall && (cnt_q >= HMAX_M1);
    assign frame_end  = (state_q == S_LOW) && !din && (cnt_q == RESET_M1);

    // Write-one-to-clear; a hardware set in the same cycle overrides the clear.
    assign clr          = (data_write && address == 4'h0) ? data_in[3:0] : 4'h0;
    assign valid_d      = (valid_q & ~clr[0]) | capture;
    assign frame_done_d = (frame_done_q & ~clr[1]) | frame_end;
    assign error_d      = (error_q & ~clr[2]) | high_err | (frame_end && bit_cnt_q != 5'd0);
    assign overrun_d    = (overrun_q & ~clr[3]) | (capture & valid_q);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RESYNC;
            din_q        <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            index_q      <= '0;
            count_q      <= '0;
            g_q          <= '0;
            r_q          <= '0;
            b_q          <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            din_q        <= din;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
            overrun_q    <= overrun_d;
            if (data_write && address == 4'h1) index_q <= data_in;

            case (state_q)
                S_RESYNC: begin
                    if (din) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_q == RESET_M1) state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (rise) begin
                        state_q <= S_HIGH;
                        cnt_q   <= CNT_ONE;
                        count_q <= '0;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        shift_q <= shift_d[22:0];
                        cnt_q   <= CNT_ONE;
                        state_q <= S_LOW;
                        if (pixel_done) begin
                            bit_cnt_q <= '0;
                            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
                            if (idx_q != 9'h1FF) idx_q <= idx_q + 9'd1;
                            if (capture) begin
                                g_q <= shift_d[23:16];
                                r_q <= shift_d[15:8];
                                b_q <= shift_d[7:0];
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else if (high_err) begin
                        state_q   <= S_RESYNC;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state_q <= S_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else if (frame_end) begin
                        state_q   <= S_IDLE;
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= S_RESYNC;
            endcase
        end
    end

    // NOTE: the default assignment ahead of the case keeps this decoder free of latches.
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = {3'b000, busy, overrun_q, error_q, frame_done_q, valid_q};
            4'h1:    data_out = index_q;
            4'h2:    data_out = g_q;
            4'h3:    data_out = r_q;
            4'h4:    data_out = b_q;
            4'h5:    data_out = count_q;
            default: data_out = 8'h00;
        endcase
    end

endmodule
